// File: rtl/slave_pkg.sv
// Shared types and constants for the wait-state memory slave.
package slave_pkg;
  localparam int ADDR_W    = 3;
  localparam int DATA_W    = 3;
  localparam int MEM_DEPTH = 8;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} slave_state_e;
  typedef logic [DATA_W-1:0] mem_entry_t;

  function automatic mem_entry_t wrap_add(input mem_entry_t a, input mem_entry_t b);
    return a + b;
  endfunction
endpackage

// File: rtl/slave_wait_cnt.sv
// Loadable down-counter; done is high while the count sits at 1.
module slave_wait_cnt #(
  parameter int CNT_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                en,
  input  logic [CNT_BITS-1:0] load_val,
  output logic                done
);
  logic [CNT_BITS-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (en && cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign done = (cnt == CNT_BITS'(1));
endmodule

// File: rtl/wait_state_slave.sv
// Memory slave that acks each request after WAIT_CYC wait states, then writes it.
// Build option SLAVE_ACCUM_EN turns the write into a 3-bit read-modify-add.
module wait_state_slave
  import slave_pkg::*;
#(
  parameter int WAIT_CYC = 2,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] value_in,
  output logic              ready,
  output logic              busy,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  wr_count
);
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);

  slave_state_e      state, state_nxt;
  logic [ADDR_W-1:0] cap_addr;
  mem_entry_t        cap_value;
  mem_entry_t        mem [MEM_DEPTH];
  logic              cnt_done;
  logic              take;

  assign take = (state == IDLE) && valid;

  slave_wait_cnt #(.CNT_BITS(4)) u_wait_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (take),
    .en       (state == WAIT),
    .load_val (WAIT_LD),
    .done     (cnt_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (valid) state_nxt = (WAIT_CYC == 0) ? ACK : WAIT;
      WAIT: if (cnt_done) state_nxt = ACK;
      ACK:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == ACK);
    busy  = (state == WAIT) || (state == ACK);
  end

  // Capture in IDLE only; the write commits on the edge leaving ACK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_addr  <= '0;
      cap_value <= '0;
      wr_count  <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (take) begin
        cap_addr  <= addr_in;
        cap_value <= value_in;
      end
      if (state == ACK) begin
`ifdef SLAVE_ACCUM_EN
        mem[cap_addr] <= wrap_add(mem[cap_addr], cap_value);
`else
        mem[cap_addr] <= cap_value;
`endif
        wr_count <= wr_count + 1'b1;
      end
    end
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: tb/tb_wait_state_slave.sv
// Directed bench: a WAIT_CYC=2 slave for timing/reset cases, a WAIT_CYC=0 slave for counter wrap.
module tb_wait_state_slave;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid, ready, busy;
  logic [2:0] addr_in, value_in, rd_addr, rd_data;
  logic [7:0] wr_count;
  logic       valid2, ready2, busy2;
  logic [2:0] addr2, value2, rd_addr2, rd_data2;
  logic [7:0] wr_count2;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  wait_state_slave #(.WAIT_CYC(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .addr_in(addr_in), .value_in(value_in),
    .ready(ready), .busy(busy), .rd_addr(rd_addr), .rd_data(rd_data), .wr_count(wr_count)
  );

  wait_state_slave #(.WAIT_CYC(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .valid(valid2), .addr_in(addr2), .value_in(value2),
    .ready(ready2), .busy(busy2), .rd_addr(rd_addr2), .rd_data(rd_data2), .wr_count(wr_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_req(input logic [2:0] a, input logic [2:0] v);
    @(negedge clk);
    valid = 1'b1; addr_in = a; value_in = v;
    @(negedge clk);
    valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    valid = 1'b0; addr_in = '0; value_in = '0; rd_addr = '0;
    valid2 = 1'b0; addr2 = '0; value2 = '0; rd_addr2 = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wr_count", wr_count, 8'd0);
    rst_n = 1'b1;

    // Single write (5,6): capture at E0, ready in the cycle after E2, data after E3.
    @(negedge clk);
    valid = 1'b1; addr_in = 3'd5; value_in = 3'd6; rd_addr = 3'd5;
    @(negedge clk);
    valid = 1'b0;
    chk("single_busy_e0", busy, 1'b1);
    chk("single_ready_e0", ready, 1'b0);
    @(negedge clk);
    chk("single_ready_e1", ready, 1'b0);
    @(negedge clk);
    chk("single_ready_e2", ready, 1'b1);
    chk("single_old_data_in_ack", rd_data, 3'd0);
    @(negedge clk);
    chk("single_ready_e3", ready, 1'b0);
    chk("single_busy_e3", busy, 1'b0);
    chk("single_rd_data", rd_data, 3'd6);
    chk("single_wr_count", wr_count, 8'd1);

    // Back-to-back with valid held: second capture at E4, ready pulses after E2 and E6.
    valid = 1'b1; addr_in = 3'd1; value_in = 3'd3;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 1) begin addr_in = 3'd2; value_in = 3'd7; end
      if (n == 5) valid = 1'b0;
      chk($sformatf("b2b_ready_n%0d", n), ready, (n == 3 || n == 7));
    end
    rd_addr = 3'd1; #1 chk("b2b_mem1", rd_data, 3'd3);
    rd_addr = 3'd2; #1 chk("b2b_mem2", rd_data, 3'd7);
    chk("b2b_wr_count", wr_count, 8'd3);

    // Inputs changed during WAIT are ignored.
    @(negedge clk);
    valid = 1'b1; addr_in = 3'd4; value_in = 3'd2;
    @(negedge clk);
    valid = 1'b0; addr_in = 3'd7; value_in = 3'd5;
    repeat (4) @(negedge clk);
    rd_addr = 3'd4; #1 chk("midwait_mem4", rd_data, 3'd2);
    rd_addr = 3'd7; #1 chk("midwait_mem7", rd_data, 3'd0);
    chk("midwait_wr_count", wr_count, 8'd4);

    // Reset asserted mid-WAIT clears everything and aborts the request.
    @(negedge clk);
    valid = 1'b1; addr_in = 3'd6; value_in = 3'd5;
    @(negedge clk);
    valid = 1'b0;
    chk("rstmid_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_ready", ready, 1'b0);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_wr_count", wr_count, 8'd0);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i); #1;
      chk($sformatf("rstmid_mem%0d", i), rd_data, 3'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    rd_addr = 3'd6; #1 chk("rstmid_no_write", rd_data, 3'd0);
    chk("rstmid_wr_count_after", wr_count, 8'd0);

    // Two writes to entry 3: overwrite gives 3, accumulate gives (6+3) mod 8 = 1.
    write_req(3'd3, 3'd6);
    write_req(3'd3, 3'd3);
    rd_addr = 3'd3; #1;
`ifdef SLAVE_ACCUM_EN
    chk("accum_mem3", rd_data, 3'd1);
`else
    chk("overwrite_mem3", rd_data, 3'd3);
`endif
    chk("accum_wr_count", wr_count, 8'd2);

    // WAIT_CYC=0 slave: 256 back-to-back writes to entry 0, counter wraps to 0.
    @(negedge clk);
    valid2 = 1'b1; addr2 = 3'd0; value2 = 3'd0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (i < 4 || i > 251) chk($sformatf("wrap_ready_ack%0d", i), ready2, 1'b1);
      @(negedge clk);
      if (i < 4 || i > 251) chk($sformatf("wrap_ready_idle%0d", i), ready2, 1'b0);
      if (i == 254) chk("wrap_count_255", wr_count2, 8'd255);
      value2 = 3'(i + 1);
      if (i == 254) valid2 = 1'b1;
      if (i == 255) valid2 = 1'b0;
    end
    @(negedge clk);
    chk("wrap_wr_count", wr_count2, 8'd0);
    chk("wrap_busy", busy2, 1'b0);
    rd_addr2 = 3'd0; #1;
`ifdef SLAVE_ACCUM_EN
    chk("wrap_mem0", rd_data2, 3'd0);
`else
    chk("wrap_mem0", rd_data2, 3'd7);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
